// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Owns the single register-file write port. The WB stage always wins. Results
//   from the long-latency unit wait in a small FIFO and drain when WB is idle.
//   The block also provides a hazard lookup (chk_hit) and a starvation bubble
//   request (stall_req).
//   Optional feature macro: RF_CLEAR_ON_RESET_EN. When it is defined, the block
//   writes zero to r1..r31 after reset before it accepts normal traffic.
module rf_write_arbiter #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wb_we,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic        ext_valid,
   output logic        ext_ready,
   input  logic [4:0]  ext_addr,
   input  logic [31:0] ext_data,
   output logic        rf_we,
   output logic [4:0]  rf_addr,
   output logic [31:0] rf_data,
   input  logic [4:0]  chk_addr,
   output logic        chk_hit,
   output logic        stall_req,
   output logic        init_busy
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

   // FIFO storage. Addresses and data are not reset; only the valid bits are.
   logic [4:0]       addr_r [DEPTH];
   logic [31:0]      data_r [DEPTH];
   logic [DEPTH-1:0] valid_r;
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;

   logic [SW-1:0]    starve_r;
   logic             stall_r;
   logic             rf_we_r;
   logic [4:0]       rf_addr_r;
   logic [31:0]      rf_data_r;

   logic             run_s;
   logic             init_busy_s;
   logic             head_live_s;
   logic             wb_issue_s;
   logic             pop_s;
   logic             push_s;
   logic             blocked_s;
   logic             ext_ready_s;
   logic             hit_s;
   logic             rf_we_s;
   logic [4:0]       rf_addr_s;
   logic [31:0]      rf_data_s;

`ifdef RF_CLEAR_ON_RESET_EN
   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   logic [0:0] state_r;
   logic [4:0] clr_addr_r;

   // Clear sequencer: after reset, walk r1..r31 once, then enter RUN.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= ST_CLEAR;
         clr_addr_r <= 5'd1;
      end else begin
         case (state_r)
            ST_CLEAR: begin
               if (clr_addr_r == 5'd31) begin
                  state_r <= ST_RUN;
               end else begin
                  state_r <= ST_CLEAR;
               end
               clr_addr_r <= clr_addr_r + 5'd1;
            end
            ST_RUN: begin
               state_r    <= ST_RUN;
               clr_addr_r <= clr_addr_r;
            end
            default: begin
               state_r    <= ST_RUN;
               clr_addr_r <= 5'd1;
            end
         endcase
      end
   end

   assign init_busy_s = (state_r == ST_CLEAR);
   assign run_s       = (state_r == ST_RUN);
`else
   assign init_busy_s = 1'b0;
   assign run_s       = 1'b1;
`endif

   // A dead head is an entry that was killed by WB or that targeted r0.
   // The block pops a dead head without writing it.
   assign head_live_s = (count_r != {CW{1'b0}}) && valid_r[rd_ptr_r];
   assign wb_issue_s  = run_s && wb_we && (wb_addr != 5'd0);
   assign pop_s       = run_s && !wb_issue_s && (count_r != {CW{1'b0}});
   assign blocked_s   = wb_issue_s && head_live_s;
   assign ext_ready_s = rst_n && (count_r < DEPTH_C) && !init_busy_s;
   assign push_s      = ext_valid && ext_ready_s;

   // FIFO control.
   // WB kills older entries to the same register. A push in the same cycle
   // lands after the kill, so the new entry survives.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_r  <= {DEPTH{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (wb_issue_s) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (addr_r[i] == wb_addr) begin
                  valid_r[i] <= 1'b0;
               end
            end
         end
         if (pop_s) begin
            valid_r[rd_ptr_r] <= 1'b0;
            rd_ptr_r          <= rd_ptr_r + 1'b1;
         end
         if (push_s) begin
            addr_r[wr_ptr_r]  <= ext_addr;
            data_r[wr_ptr_r]  <= ext_data;
            valid_r[wr_ptr_r] <= (ext_addr != 5'd0);
            wr_ptr_r          <= wr_ptr_r + 1'b1;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end

   // Starvation tracking.
   // stall_req rises the cycle after the counter reaches its limit and falls
   // once the head pops.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         starve_r <= {SW{1'b0}};
         stall_r  <= 1'b0;
      end else begin
         if (pop_s) begin
            starve_r <= {SW{1'b0}};
         end else if (blocked_s && (starve_r != LIMIT_C)) begin
            starve_r <= starve_r + 1'b1;
         end else begin
            starve_r <= starve_r;
         end
         if (pop_s) begin
            stall_r <= 1'b0;
         end else if (starve_r == LIMIT_C) begin
            stall_r <= 1'b1;
         end else begin
            stall_r <= stall_r;
         end
      end
   end

   // Select the next write: clear sequence, then WB, then the live FIFO head.
   always_comb begin
      rf_we_s   = 1'b0;
      rf_addr_s = 5'd0;
      rf_data_s = 32'd0;
`ifdef RF_CLEAR_ON_RESET_EN
      if (init_busy_s) begin
         rf_we_s   = 1'b1;
         rf_addr_s = clr_addr_r;
         rf_data_s = 32'd0;
      end else
`endif
      if (wb_issue_s) begin
         rf_we_s   = 1'b1;
         rf_addr_s = wb_addr;
         rf_data_s = wb_data;
      end else if (pop_s && head_live_s) begin
         rf_we_s   = 1'b1;
         rf_addr_s = addr_r[rd_ptr_r];
         rf_data_s = data_r[rd_ptr_r];
      end else begin
         rf_we_s   = 1'b0;
         rf_addr_s = 5'd0;
         rf_data_s = 32'd0;
      end
   end

   // Register the write-port outputs. This gives one cycle of latency.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rf_we_r   <= 1'b0;
         rf_addr_r <= 5'd0;
         rf_data_r <= 32'd0;
      end else begin
         rf_we_r   <= rf_we_s;
         rf_addr_r <= rf_addr_s;
         rf_data_r <= rf_data_s;
      end
   end

   // Hazard lookup: does any live buffered result target chk_addr?
   always_comb begin
      hit_s = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_r[i] && (addr_r[i] == chk_addr)) begin
            hit_s = 1'b1;
         end else begin
            hit_s = hit_s;
         end
      end
   end

   assign chk_hit   = hit_s && (chk_addr != 5'd0);
   assign ext_ready = ext_ready_s;
   assign rf_we     = rf_we_r;
   assign rf_addr   = rf_addr_r;
   assign rf_data   = rf_data_r;
   assign stall_req = stall_r | init_busy_s;
   assign init_busy = init_busy_s;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed testbench for rf_write_arbiter (DEPTH=2, STARVE_LIMIT=4).
// It applies a table of vectors, then runs hand-written multi-cycle sequences.
module tb_rf_write_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        ext_valid;
   logic        ext_ready;
   logic [4:0]  ext_addr;
   logic [31:0] ext_data;
   logic        rf_we;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;
   logic [4:0]  chk_addr;
   logic        chk_hit;
   logic        stall_req;
   logic        init_busy;

   int tests = 0;
   int fails = 0;

   rf_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .ext_valid(ext_valid), .ext_ready(ext_ready),
      .ext_addr(ext_addr), .ext_data(ext_data),
      .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
      .chk_addr(chk_addr), .chk_hit(chk_hit),
      .stall_req(stall_req), .init_busy(init_busy)
   );

   always #5 clk = ~clk;

   // Each vector holds inputs for one cycle.
   // x_rdy and x_hit are checked before the edge; the rest are checked after it.
   typedef struct {
      logic        rst;
      logic        wwe;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        ev;
      logic [4:0]  ea;
      logic [31:0] ed;
      logic [4:0]  ca;
      logic        x_rdy;
      logic        x_hit;
      logic        x_we;
      logic [4:0]  x_a;
      logic [31:0] x_d;
      logic        x_st;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic wwe, input logic [4:0] wa,
                      input logic [31:0] wd, input logic ev, input logic [4:0] ea,
                      input logic [31:0] ed, input logic [4:0] ca, input logic xr,
                      input logic xh, input logic xw, input logic [4:0] xa,
                      input logic [31:0] xd, input logic xs);
      vec_t v;
      v.rst = rst; v.wwe = wwe; v.wa = wa; v.wd = wd; v.ev = ev; v.ea = ea;
      v.ed = ed; v.ca = ca; v.x_rdy = xr; v.x_hit = xh; v.x_we = xw;
      v.x_a = xa; v.x_d = xd; v.x_st = xs;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
      ext_valid = 1'b0; ext_addr = 5'd0; ext_data = 32'd0; chk_addr = 5'd0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      idle_inputs();
`ifdef RF_CLEAR_ON_RESET_EN
      // Clear sequence. During it, wb_we and ext_valid must be ignored.
      step(); step();
      check("rst_we", {31'd0, rf_we}, 32'd0);
      check("rst_busy", {31'd0, init_busy}, 32'd1);
      wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h5555; ext_valid = 1'b1; ext_addr = 5'd6;
      rst_n = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         check("clr_ready", {31'd0, ext_ready}, 32'd0);
         step();
         check("clr_we", {31'd0, rf_we}, 32'd1);
         check("clr_addr", {27'd0, rf_addr}, c);
         check("clr_data", rf_data, 32'd0);
         check("clr_stall", {31'd0, stall_req}, 32'd1);
      end
      rst_n = 1'b0;
      step();
      check("clr_rst_we", {31'd0, rf_we}, 32'd0);
      rst_n = 1'b1;
      for (int c = 1; c <= 31; c++) begin
         check("clr2_ready", {31'd0, ext_ready}, 32'd0);
         step();
         check("clr2_we", {31'd0, rf_we}, 32'd1);
         check("clr2_addr", {27'd0, rf_addr}, c);
         check("clr2_data", rf_data, 32'd0);
         check("clr2_busy", {31'd0, init_busy}, (c < 31) ? 32'd1 : 32'd0);
      end
      ext_valid = 1'b0;
      check("run_ready", {31'd0, ext_ready}, 32'd1);
      step();
      check("run_wb_we", {31'd0, rf_we}, 32'd1);
      check("run_wb_addr", {27'd0, rf_addr}, 32'd5);
      check("run_wb_data", rf_data, 32'h5555);
`else
      // rst,wwe,wa,wd,      ev,ea,ed,   ca,  rdy,hit,we,a,d,       stall
      add(0,0,5'd0,32'h0,        0,5'd0,32'h0,   5'd0,  0,0,0,5'd0,32'h0,0);
      add(0,1,5'd5,32'h1234,     0,5'd0,32'h0,   5'd0,  0,0,0,5'd0,32'h0,0);
      add(1,1,5'd5,32'hDEADBEEF, 0,5'd0,32'h0,   5'd0,  1,0,1,5'd5,32'hDEADBEEF,0);
      add(1,0,5'd0,32'h0,        0,5'd0,32'h0,   5'd0,  1,0,0,5'd0,32'h0,0);
      add(1,1,5'd0,32'hAAAA,     1,5'd0,32'h55,  5'd0,  1,0,0,5'd0,32'h0,0);
      add(1,0,5'd0,32'h0,        0,5'd0,32'h0,   5'd0,  1,0,0,5'd0,32'h0,0);
      add(1,0,5'd0,32'h0,        0,5'd0,32'h0,   5'd0,  1,0,0,5'd0,32'h0,0);
      add(1,1,5'd20,32'hA0,      1,5'd3,32'h1,   5'd0,  1,0,1,5'd20,32'hA0,0);
      add(1,1,5'd21,32'hA1,      1,5'd4,32'h2,   5'd3,  1,1,1,5'd21,32'hA1,0);
      add(1,0,5'd0,32'h0,        1,5'd5,32'h99,  5'd4,  0,1,1,5'd3,32'h1,0);
      add(1,0,5'd0,32'h0,        0,5'd0,32'h0,   5'd5,  1,0,1,5'd4,32'h2,0);
      add(1,0,5'd0,32'h0,        0,5'd0,32'h0,   5'd4,  1,0,0,5'd0,32'h0,0);
      add(1,1,5'd30,32'h30,      1,5'd7,32'h11,  5'd0,  1,0,1,5'd30,32'h30,0);
      add(1,1,5'd7,32'h22,       0,5'd0,32'h0,   5'd7,  1,1,1,5'd7,32'h22,0);
      add(1,0,5'd0,32'h0,        0,5'd0,32'h0,   5'd7,  1,0,0,5'd0,32'h0,0);
      add(1,0,5'd0,32'h0,        0,5'd0,32'h0,   5'd0,  1,0,0,5'd0,32'h0,0);
      add(1,1,5'd8,32'h88,       1,5'd8,32'h08,  5'd0,  1,0,1,5'd8,32'h88,0);
      add(1,0,5'd0,32'h0,        0,5'd0,32'h0,   5'd8,  1,1,1,5'd8,32'h08,0);
      add(1,0,5'd0,32'h0,        0,5'd0,32'h0,   5'd8,  1,0,0,5'd0,32'h0,0);
      add(1,1,5'd1,32'h100,      1,5'd9,32'h9,   5'd0,  1,0,1,5'd1,32'h100,0);
      add(1,1,5'd1,32'h101,      0,5'd0,32'h0,   5'd9,  1,1,1,5'd1,32'h101,0);
      add(1,1,5'd1,32'h102,      0,5'd0,32'h0,   5'd9,  1,1,1,5'd1,32'h102,0);
      add(1,1,5'd1,32'h103,      0,5'd0,32'h0,   5'd9,  1,1,1,5'd1,32'h103,0);
      add(1,1,5'd1,32'h104,      0,5'd0,32'h0,   5'd9,  1,1,1,5'd1,32'h104,0);
      add(1,1,5'd1,32'h105,      0,5'd0,32'h0,   5'd9,  1,1,1,5'd1,32'h105,1);
      add(1,1,5'd1,32'h106,      0,5'd0,32'h0,   5'd9,  1,1,1,5'd1,32'h106,1);
      add(1,0,5'd0,32'h0,        0,5'd0,32'h0,   5'd9,  1,1,1,5'd9,32'h9,0);
      add(1,0,5'd0,32'h0,        0,5'd0,32'h0,   5'd9,  1,0,0,5'd0,32'h0,0);
      add(1,1,5'd2,32'h2,        1,5'd12,32'hC,  5'd0,  1,0,1,5'd2,32'h2,0);
      add(0,0,5'd0,32'h0,        0,5'd0,32'h0,   5'd12, 0,1,0,5'd0,32'h0,0);
      add(1,0,5'd0,32'h0,        0,5'd0,32'h0,   5'd12, 1,0,0,5'd0,32'h0,0);

      for (int i = 0; i < vecs.size(); i++) begin
         rst_n = vecs[i].rst;
         wb_we = vecs[i].wwe; wb_addr = vecs[i].wa; wb_data = vecs[i].wd;
         ext_valid = vecs[i].ev; ext_addr = vecs[i].ea; ext_data = vecs[i].ed;
         chk_addr = vecs[i].ca;
         #1;
         check($sformatf("v%0d_ready", i), {31'd0, ext_ready}, {31'd0, vecs[i].x_rdy});
         check($sformatf("v%0d_hit", i), {31'd0, chk_hit}, {31'd0, vecs[i].x_hit});
         step();
         check($sformatf("v%0d_we", i), {31'd0, rf_we}, {31'd0, vecs[i].x_we});
         if (vecs[i].x_we) begin
            check($sformatf("v%0d_addr", i), {27'd0, rf_addr}, {27'd0, vecs[i].x_a});
            check($sformatf("v%0d_data", i), rf_data, vecs[i].x_d);
         end
         check($sformatf("v%0d_stall", i), {31'd0, stall_req}, {31'd0, vecs[i].x_st});
         check($sformatf("v%0d_busy", i), {31'd0, init_busy}, 32'd0);
      end

      // Back-to-back stream with WB idle. Each push pops one cycle later,
      // so the pointers wrap while push and pop happen together.
      idle_inputs();
      for (int k = 0; k < 4; k++) begin
         ext_valid = 1'b1; ext_addr = 5'(10 + k); ext_data = 32'h100 + k;
         #1;
         check("strm_ready", {31'd0, ext_ready}, 32'd1);
         step();
         if (k > 0) begin
            check("strm_we", {31'd0, rf_we}, 32'd1);
            check("strm_addr", {27'd0, rf_addr}, 32'(10 + k - 1));
            check("strm_data", rf_data, 32'h100 + k - 1);
         end
      end
      ext_valid = 1'b0;
      step();
      check("strm_last_we", {31'd0, rf_we}, 32'd1);
      check("strm_last_addr", {27'd0, rf_addr}, 32'd13);
      check("strm_last_data", rf_data, 32'h103);
      step();
      check("strm_idle_we", {31'd0, rf_we}, 32'd0);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
